hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Producer-side companion to the forwarding interface. It tracks destination registers in flight through the EX, MEM and WB stages.
- Each cycle it answers decode with two things for the instruction's source registers: where the youngest value lives, and whether decode must stall (load-use).
- It sits between decode and the execute latch, is driven by the pipeline advance enable, and feeds the forwarding muxes plus the hazard stall/bubble control.

Parameters:
- NREG, 32, number of architectural registers; register 0 is hardwired zero.
- RW, 5, register index width (clog2 NREG).
- CW, 16, width of the saturating stall-cycle counter.

Ports:
- CLK  in  1  system clock
- nRST  in  1  synchronous active-low reset
- advance  in  1  pipeline latches update this cycle (ihit and no dcache wait)
- flush  in  1  squash the instruction entering EX (branch/jump taken)
- dec_valid  in  1  decode holds a real instruction
- dec_rs  in  RW  decode source register 1
- dec_rt  in  RW  decode source register 2
- dec_rd  in  RW  decode destination register
- dec_wen  in  1  decode instruction writes a register
- dec_load  in  1  decode instruction is a load
- stall  out  1  hold PC and IF/ID, insert bubble into EX
- fwd_rs  out  2  source for rs: 00 regfile, 01 EX, 10 MEM, 11 WB
- fwd_rt  out  2  same encoding for rt
- stall_cnt  out  CW  saturating count of load-use stall cycles

Behaviour:
- State: three entries EX, MEM, WB. Each holds {valid, rd, wen, load}.
- Reset (nRST low at a CLK edge):
  - all entries invalid; FSM to RUN; stall_cnt = 0.
  - Because stall and fwd_* are combinational from invalid state, they read 0 / 00 in the cycle after reset.
  - Reset mid-stall clears everything; there is no residual bubble.
- Shift, on CLK edge with advance=1:
  - WB <= MEM; MEM <= EX.
  - EX <= decode entry only if dec_valid && !stall && !flush; otherwise EX <= bubble (valid=0).
  - flush has priority over issue.
- advance=0: all entries hold, stall_cnt holds, FSM holds.
- Match rule: an entry matches a source s when valid && wen && rd == s && s != 0. A source of 0 always returns 00.
- Forward select priority: youngest wins, EX > MEM > WB, else 00. Purely combinational; zero-cycle latency from dec_* and state.
- Load-use stall: stall = dec_valid && EX.valid && EX.load && EX.wen && EX.rd != 0 && (EX.rd == dec_rs || EX.rd == dec_rt).
  - While stall=1, fwd_* still report the match (EX); consumers ignore them.
  - After one advance the load sits in MEM, stall drops, and fwd reports 10.
- FSM: RUN, LDSTALL.
  - RUN -> LDSTALL when stall && advance.
  - LDSTALL -> RUN on the next advance. LDSTALL never re-asserts stall for the same load, since that load has moved to MEM.
  - LDSTALL with advance=0 holds.
  - FSM state is observable only through stall_cnt behaviour and is kept for debug.
- stall_cnt increments by 1 on each CLK edge where stall && advance, and saturates at all-ones.
- Simultaneous flush && stall: the bubble is inserted either way. stall still asserts; PC redirect is owned by the branch logic.
- Decode writing a register it reads (rd == rs) does not self-match; only EX/MEM/WB entries are compared.

Decomposition:
- Shared package (cpu_types_pkg):
  - regbits_t (RW-bit register index);
  - fwd_sel_t enum {FWD_RF, FWD_EX, FWD_MEM, FWD_WB};
  - sb_entry_t packed struct {valid, rd, wen, load}.
- Sub-module hazard_match: pure combinational youngest-match priority for one source. Instantiated twice, for rs and rt.
- Interface hazard_scoreboard_if carries the ports above, with modport hsb (unit side) and modport dec (decode side).

Test Plan:
- Reset with nRST=0 for 2 cycles, then dec_rs=3 -> fwd_rs=00, stall=0, stall_cnt=0.
- Issue add rd=5, then next cycle dec_rs=5 with advance=1 each cycle -> fwd_rs=01. Following cycle (entry in MEM) with no newer writer -> 10. Then 11 in WB. Then 00.
- Issue lw rd=8, then dec_rt=8 -> stall=1 for exactly one advancing cycle, bubble in EX, then fwd_rt=10, stall_cnt=1.
- Same load-use with advance=0 for 3 cycles -> stall stays 1, stall_cnt stays 0 until the advancing edge, then 1.
- Writers rd=4 in EX and WB simultaneously, dec_rs=4 -> fwd_rs=01. Writer with rd=0 in EX and dec_rs=0 -> 00, no stall.
- flush=1 with dec_valid=1, rd=7, then dec_rs=7 next cycle -> fwd_rs=00. Force stall_cnt to all-ones via repeated load-use -> remains all-ones.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the hazard scoreboard: register index, forward-select
// encoding and the per-stage scoreboard entry.
package cpu_types_pkg;
  localparam int NREG = 32;
  localparam int RW   = $clog2(NREG);

  typedef logic [RW-1:0] regbits_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_sel_t;

  typedef struct packed {
    logic     valid;
    regbits_t rd;
    logic     wen;
    logic     load;
  } sb_entry_t;

  typedef enum logic {ST_RUN, ST_LDSTALL} sb_state_t;

  // r0 is hardwired zero, so it never matches an in-flight writer.
  function automatic logic entry_hit(sb_entry_t e, regbits_t s);
    return e.valid && e.wen && (e.rd == s) && (s != '0);
  endfunction
endpackage

// File: rtl/hazard_scoreboard_if.sv
// Port bundle between decode and the hazard scoreboard.
interface hazard_scoreboard_if #(parameter int CW = 16);
  import cpu_types_pkg::*;
  logic          CLK;
  logic          nRST;
  logic          advance;
  logic          flush;
  logic          dec_valid;
  regbits_t      dec_rs;
  regbits_t      dec_rt;
  regbits_t      dec_rd;
  logic          dec_wen;
  logic          dec_load;
  logic          stall;
  logic [1:0]    fwd_rs;
  logic [1:0]    fwd_rt;
  logic [CW-1:0] stall_cnt;

  modport hsb (
    input  CLK, nRST, advance, flush, dec_valid, dec_rs, dec_rt, dec_rd, dec_wen, dec_load,
    output stall, fwd_rs, fwd_rt, stall_cnt
  );
  modport dec (
    output advance, flush, dec_valid, dec_rs, dec_rt, dec_rd, dec_wen, dec_load,
    input  CLK, nRST, stall, fwd_rs, fwd_rt, stall_cnt
  );
endinterface

// File: rtl/hazard_match.sv
// Youngest-writer lookup for one source register across EX/MEM/WB.
module hazard_match
  import cpu_types_pkg::*;
(
  input  regbits_t  src,
  input  sb_entry_t ex_e,
  input  sb_entry_t mem_e,
  input  sb_entry_t wb_e,
  output fwd_sel_t  sel
);
  // Oldest first so the youngest hit overwrites.
  always_comb begin
    sel = FWD_RF;
    if (entry_hit(wb_e,  src)) sel = FWD_WB;
    if (entry_hit(mem_e, src)) sel = FWD_MEM;
    if (entry_hit(ex_e,  src)) sel = FWD_EX;
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks destination registers in EX/MEM/WB; drives forward selects and
// the load-use stall for the instruction in decode.
module hazard_scoreboard
  import cpu_types_pkg::*;
#(
  parameter int CW = 16
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          advance,
  input  logic          flush,
  input  logic          dec_valid,
  input  logic [RW-1:0] dec_rs,
  input  logic [RW-1:0] dec_rt,
  input  logic [RW-1:0] dec_rd,
  input  logic          dec_wen,
  input  logic          dec_load,
  output logic          stall,
  output logic [1:0]    fwd_rs,
  output logic [1:0]    fwd_rt,
  output logic [CW-1:0] stall_cnt
);
  sb_entry_t     ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  sb_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  sb_entry_t     dec_e;
  fwd_sel_t      sel_rs, sel_rt;

  hazard_match u_match_rs (.src(dec_rs), .ex_e(ex_q), .mem_e(mem_q), .wb_e(wb_q), .sel(sel_rs));
  hazard_match u_match_rt (.src(dec_rt), .ex_e(ex_q), .mem_e(mem_q), .wb_e(wb_q), .sel(sel_rt));

  assign fwd_rs    = sel_rs;
  assign fwd_rt    = sel_rt;
  assign stall_cnt = cnt_q;

  always_comb begin
    stall = dec_valid && ex_q.valid && ex_q.load && ex_q.wen && (ex_q.rd != '0) &&
            ((ex_q.rd == dec_rs) || (ex_q.rd == dec_rt));

    // Flush and stall both turn the EX slot into a bubble.
    dec_e.valid = dec_valid && !stall && !flush;
    dec_e.rd    = dec_rd;
    dec_e.wen   = dec_wen;
    dec_e.load  = dec_load;

    ex_d    = ex_q;
    mem_d   = mem_q;
    wb_d    = wb_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    if (advance) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      ex_d  = dec_e.valid ? dec_e : '0;
      if (stall && (cnt_q != {CW{1'b1}})) cnt_d = cnt_q + 1'b1;
      case (state_q)
        ST_RUN:     if (stall) state_d = ST_LDSTALL;
        ST_LDSTALL: state_d = ST_RUN;
        default:    state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      cnt_q   <= '0;
      state_q <= ST_RUN;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (CW shrunk to 4 to reach saturation).
module tb_hazard_scoreboard;
  localparam int CW = 4;

  hazard_scoreboard_if #(.CW(CW)) hif ();

  hazard_scoreboard #(.CW(CW)) dut (
    .CLK(hif.CLK), .nRST(hif.nRST), .advance(hif.advance), .flush(hif.flush),
    .dec_valid(hif.dec_valid), .dec_rs(hif.dec_rs), .dec_rt(hif.dec_rt),
    .dec_rd(hif.dec_rd), .dec_wen(hif.dec_wen), .dec_load(hif.dec_load),
    .stall(hif.stall), .fwd_rs(hif.fwd_rs), .fwd_rt(hif.fwd_rt), .stall_cnt(hif.stall_cnt)
  );

  int n_run = 0;
  int n_fail = 0;

  initial hif.CLK = 1'b0;
  always #5 hif.CLK = ~hif.CLK;

  task automatic tick();
    @(posedge hif.CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic dec(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] rd, input logic wen, input logic ld);
    hif.dec_valid = v;
    hif.dec_rs    = rs;
    hif.dec_rt    = rt;
    hif.dec_rd    = rd;
    hif.dec_wen   = wen;
    hif.dec_load  = ld;
    #1;
  endtask

  task automatic drain();
    dec(0, 0, 0, 0, 0, 0);
    repeat (3) tick();
  endtask

  initial begin
    hif.nRST = 0; hif.advance = 0; hif.flush = 0;
    dec(0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    hif.nRST = 1;

    // Reset state
    dec(1, 3, 0, 0, 0, 0);
    chk("rst_fwd_rs", hif.fwd_rs, 2'b00);
    chk("rst_stall", hif.stall, 0);
    chk("rst_cnt", hif.stall_cnt, 0);

    // ALU writer rd=5 walks EX -> MEM -> WB -> gone
    hif.advance = 1;
    dec(1, 0, 0, 5, 1, 0);
    tick();
    dec(1, 5, 0, 0, 0, 0);
    chk("alu_ex", hif.fwd_rs, 2'b01);
    chk("alu_ex_rt", hif.fwd_rt, 2'b00);
    tick();
    chk("alu_mem", hif.fwd_rs, 2'b10);
    tick();
    chk("alu_wb", hif.fwd_rs, 2'b11);
    tick();
    chk("alu_gone", hif.fwd_rs, 2'b00);
    drain();

    // Load-use on rt, advancing
    dec(1, 0, 0, 8, 1, 1);
    tick();
    dec(1, 0, 8, 0, 0, 0);
    chk("lu_stall", hif.stall, 1);
    chk("lu_fwd_ex", hif.fwd_rt, 2'b01);
    chk("lu_cnt0", hif.stall_cnt, 0);
    tick();
    chk("lu_stall_drop", hif.stall, 0);
    chk("lu_fwd_mem", hif.fwd_rt, 2'b10);
    chk("lu_cnt1", hif.stall_cnt, 1);
    tick();
    chk("lu_fwd_wb", hif.fwd_rt, 2'b11);
    drain();

    // Load-use held for 3 non-advancing cycles
    dec(1, 0, 0, 9, 1, 1);
    tick();
    hif.advance = 0;
    dec(1, 9, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("hold_stall", hif.stall, 1);
      chk("hold_cnt", hif.stall_cnt, 1);
      tick();
    end
    chk("hold_stall_end", hif.stall, 1);
    hif.advance = 1;
    tick();
    chk("hold_cnt2", hif.stall_cnt, 2);
    chk("hold_stall_drop", hif.stall, 0);
    chk("hold_fwd_mem", hif.fwd_rs, 2'b10);
    drain();

    // rd=4 in both EX and WB: youngest wins
    dec(1, 0, 0, 4, 1, 0); tick();
    dec(0, 0, 0, 0, 0, 0); tick();
    dec(1, 0, 0, 4, 1, 0); tick();
    dec(1, 4, 4, 0, 0, 0);
    chk("dup_rs_ex", hif.fwd_rs, 2'b01);
    chk("dup_rt_ex", hif.fwd_rt, 2'b01);
    // Load to r0 in EX, rd=4 now in MEM; source r0 never matches or stalls
    dec(1, 0, 0, 0, 1, 1); tick();
    dec(1, 0, 0, 0, 0, 0);
    chk("r0_fwd_rs", hif.fwd_rs, 2'b00);
    chk("r0_fwd_rt", hif.fwd_rt, 2'b00);
    chk("r0_stall", hif.stall, 0);
    drain();

    // Flushed writer never enters EX; decode does not self-match
    hif.flush = 1;
    dec(1, 0, 0, 7, 1, 0); tick();
    hif.flush = 0;
    dec(1, 7, 0, 0, 0, 0);
    chk("flush_fwd", hif.fwd_rs, 2'b00);
    dec(1, 6, 6, 6, 1, 0);
    chk("self_rs", hif.fwd_rs, 2'b00);
    chk("self_rt", hif.fwd_rt, 2'b00);
    drain();

    // Saturation: count starts at 2, 13 more stalls reach 15
    for (int i = 0; i < 13; i++) begin
      dec(1, 0, 0, 8, 1, 1); tick();
      dec(1, 8, 0, 0, 0, 0); tick();
    end
    chk("sat_reach", hif.stall_cnt, 15);
    for (int i = 0; i < 3; i++) begin
      dec(1, 0, 0, 8, 1, 1); tick();
      dec(1, 8, 0, 0, 0, 0);
      chk("sat_stall", hif.stall, 1);
      tick();
    end
    chk("sat_hold", hif.stall_cnt, 15);

    // Reset mid-stall leaves no residue
    dec(1, 0, 0, 8, 1, 1); tick();
    dec(1, 8, 0, 0, 0, 0);
    chk("pre_rst_stall", hif.stall, 1);
    hif.nRST = 0; tick();
    hif.nRST = 1;
    chk("mid_rst_stall", hif.stall, 0);
    chk("mid_rst_fwd", hif.fwd_rs, 2'b00);
    chk("mid_rst_cnt", hif.stall_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
